// File: rtl/pixel_pkg.sv
// Shared types for the pixel stream packer: colour struct, bus width, FSM states.
package pixel_pkg;

  localparam int unsigned PIX_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  // Flatten a colour into the {r,g,b} bus ordering, r in the top byte.
  function automatic logic [PIX_W-1:0] pack_rgb(input rgb_t c);
    return {c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Pixel input handshake plus AXI4-Stream video output, bundled as one bus.
// slave: the packer's view; master: the surrounding producer/sink view.
interface pixel_stream_packer_if;
  import pixel_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_r;
  logic [7:0]       in_g;
  logic [7:0]       in_b;
  logic             in_sof;
  logic [PIX_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tuser;
  logic             m_axis_tlast;

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_sof, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );

  modport master (
    output in_valid, in_r, in_g, in_b, in_sof, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: an output register plus one overflow slot.
// s_ready_o is a flop, so there is no combinational path from m_ready_i back upstream.
module axis_skid_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              ready_q, ready_d;
  logic              push;
  logic              out_free;

  // Next-state for both slots; the skid slot only fills while the output stalls.
  always_comb begin
    push         = s_valid_i & ready_q;
    out_free     = ~out_valid_q | m_ready_i;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) begin
          out_data_d = s_data_i;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
    ready_d = ~skid_valid_d;
  end

  // Slot registers with synchronous clear; clear discards anything buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs per-pixel r/g/b into AXI4-Stream video with tuser (SOF) / tlast (EOL),
// resynchronising to the producer's in_sof marker.
// Optional: define PACKER_ERR_CNT_EN to expose err_cnt, a saturating count of
// mid-frame in_sof events.
module pixel_stream_packer
  import pixel_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                  aclk,
  input  logic                  clr,
  pixel_stream_packer_if.slave  bus
`ifdef PACKER_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             in_ready_w;
  logic             accept;
  logic             at_origin;
  logic             fwd;
  logic             tuser_c;
  logic             tlast_c;
  rgb_t             pix;
  logic [PIX_W+1:0] m_data;

  assign accept    = bus.in_valid & in_ready_w;
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign pix       = '{r: bus.in_r, g: bus.in_g, b: bus.in_b};

  // State and raster-position registers.
  always_ff @(posedge aclk) begin
    if (clr) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Leave WAIT_SOF on the first accepted start-of-frame pixel; ACTIVE is sticky.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SOF: if (accept && bus.in_sof) state_d = ACTIVE;
      ACTIVE:   state_d = ACTIVE;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // Framing and counter advance for each accepted pixel.
  // A resync pixel is emitted as (0,0), so the counters jump straight to (1,0).
  always_comb begin
    fwd     = 1'b0;
    tuser_c = 1'b0;
    tlast_c = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      WAIT_SOF: begin
        if (accept && bus.in_sof) begin
          fwd     = 1'b1;
          tuser_c = 1'b1;
          x_d     = XW'(1);
          y_d     = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          fwd = 1'b1;
          if (bus.in_sof && !at_origin) begin
            tuser_c = 1'b1;
            x_d     = XW'(1);
            y_d     = '0;
          end else begin
            tuser_c = at_origin;
            tlast_c = (x_q == X_LAST);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  axis_skid_buffer #(
    .DATA_W (PIX_W + 2)
  ) u_skid (
    .clk_i     (aclk),
    .rst_i     (clr),
    .s_valid_i (fwd),
    .s_ready_o (in_ready_w),
    .s_data_i  ({tuser_c, tlast_c, pack_rgb(pix)}),
    .m_valid_o (bus.m_axis_tvalid),
    .m_ready_i (bus.m_axis_tready),
    .m_data_o  (m_data)
  );

  assign bus.in_ready     = in_ready_w;
  assign bus.m_axis_tuser = m_data[PIX_W+1];
  assign bus.m_axis_tlast = m_data[PIX_W];
  assign bus.m_axis_tdata = m_data[PIX_W-1:0];

`ifdef PACKER_ERR_CNT_EN
  logic        resync;
  logic [15:0] err_q;

  assign resync = accept && (state_q == ACTIVE) && bus.in_sof && !at_origin;

  // Saturating count of truncated frames; only clr clears it.
  always_ff @(posedge aclk) begin
    if (clr) begin
      err_q <= '0;
    end else if (resync && (err_q != '1)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
